// File: rtl/seg7_scan_decoder_if.sv
// Display-bus bundle for the 7-segment scan decoder: multiplexed segment/anode lines
// driven by the display path, plus the decoder's readback results.
interface seg7_scan_decoder_if #(
    parameter int unsigned NDIG = 4
);
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [6:0]        seg_n;
    logic [NDIG-1:0]   an_n;
    logic              valid_o;
    logic [IW-1:0]     idx_o;
    logic [3:0]        val_o;
    logic              err_o;
    logic [4*NDIG-1:0] digits_o;
    logic [7:0]        err_cnt;

    modport master (
        output seg_n, an_n,
        input  valid_o, idx_o, val_o, err_o, digits_o, err_cnt
    );

    modport slave (
        input  seg_n, an_n,
        output valid_o, idx_o, val_o, err_o, digits_o, err_cnt
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed active-low 7-segment bus and recovers each digit once it is stable.
// Define SEG7_HEX_DECODE_EN to extend the decode table from 0..6 to 0..F.
module seg7_scan_decoder #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned STABLE_CYC = 4
) (
    input logic                clk,
    input logic                rst,
    seg7_scan_decoder_if.slave bus
);
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CW = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {StIdle, StTrack, StCommit, StHold} state_e;

    // Returns {err, val}; unknown patterns decode to error with value 0.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
`ifdef SEG7_HEX_DECODE_EN
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b0000011: decode = 5'h0B;
            7'b1000110: decode = 5'h0C;
            7'b0100001: decode = 5'h0D;
            7'b0000110: decode = 5'h0E;
            7'b0001110: decode = 5'h0F;
`endif
            default:    decode = 5'h10;
        endcase
    endfunction

    function automatic logic [IW-1:0] an_index(input logic [NDIG-1:0] an);
        an_index = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an[i]) an_index = IW'(i);
        end
    endfunction

    state_e            state_q, state_d;
    logic [6:0]        s_seg, ref_seg_q, ref_seg_d;
    logic [NDIG-1:0]   s_an, ref_an_q, ref_an_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q;
    logic [3:0]        val_q;
    logic              err_q;
    logic [4*NDIG-1:0] digits_q;
    logic [7:0]        err_cnt_q;

    logic [NDIG-1:0]   an_act;
    logic              qual, match, commit;
    logic [4:0]        dec;
    logic [IW-1:0]     cidx;

    always_comb begin
        an_act = ~s_an;
        qual   = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0) && (s_seg != 7'h7F);
        match  = (s_seg == ref_seg_q) && (s_an == ref_an_q);
        dec    = decode(ref_seg_q);
        cidx   = an_index(ref_an_q);
    end

    always_comb begin
        state_d   = state_q;
        ref_seg_d = ref_seg_q;
        ref_an_d  = ref_an_q;
        cnt_d     = cnt_q;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (qual) begin
                    state_d   = StTrack;
                    ref_seg_d = s_seg;
                    ref_an_d  = s_an;
                    cnt_d     = CW'(1);
                end
            end
            StTrack: begin
                if (!qual) begin
                    state_d = StIdle;
                end else if (match) begin
                    if (cnt_q == CW'(STABLE_CYC - 1)) begin
                        state_d = StCommit;
                        commit  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    ref_seg_d = s_seg;
                    ref_an_d  = s_an;
                    cnt_d     = CW'(1);
                end
            end
            StCommit: state_d = StHold;
            StHold: begin
                // Same frame stays parked here so it is never committed twice.
                if (!match) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            s_seg     <= 7'h7F;
            s_an      <= '1;
            ref_seg_q <= 7'h7F;
            ref_an_q  <= '1;
            cnt_q     <= '0;
            idx_q     <= '0;
            val_q     <= '0;
            err_q     <= 1'b0;
            digits_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            s_seg     <= bus.seg_n;
            s_an      <= bus.an_n;
            ref_seg_q <= ref_seg_d;
            ref_an_q  <= ref_an_d;
            cnt_q     <= cnt_d;
            if (commit) begin
                idx_q <= cidx;
                val_q <= dec[3:0];
                err_q <= dec[4];
                if (dec[4]) begin
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end else begin
                    for (int i = 0; i < NDIG; i++) begin
                        if (cidx == IW'(i)) digits_q[4*i +: 4] <= dec[3:0];
                    end
                end
            end
        end
    end

    assign bus.valid_o  = (state_q == StCommit);
    assign bus.idx_o    = idx_q;
    assign bus.val_o    = val_q;
    assign bus.err_o    = err_q;
    assign bus.digits_o = digits_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scenarios plus randomized steps
// checked against a table-driven model of digit acceptance.
module tb_seg7_scan_decoder;
    localparam int unsigned NDIG = 4;
    localparam int unsigned SC   = 4;
    localparam logic [6:0] TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
        7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`ifdef SEG7_HEX_DECODE_EN
    localparam int NVALID = 16;
`else
    localparam int NVALID = 7;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.NDIG(NDIG)) bus ();
    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    logic [1:0] cap_idx;
    logic [3:0] cap_val;
    logic       cap_err;
    logic [3:0] exp_dig [NDIG];
    int         exp_err_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (bus.valid_o === 1'b1) begin
                pulses++;
                cap_idx = bus.idx_o;
                cap_val = bus.val_o;
                cap_err = bus.err_o;
            end
        end
    endtask

    task automatic drive(input logic [6:0] seg, input logic [3:0] an);
        bus.seg_n = seg;
        bus.an_n  = an;
    endtask

    function automatic logic [15:0] exp_vec();
        logic [15:0] v;
        for (int i = 0; i < NDIG; i++) v[4*i +: 4] = exp_dig[i];
        return v;
    endfunction

    function automatic void model_decode(input logic [6:0] s, output logic [3:0] v,
                                         output logic e);
        logic [6:0] t [16];
        t = TBL;
        v = 4'd0;
        e = 1'b1;
        for (int i = 0; i < NVALID; i++) begin
            if (t[i] == s) begin
                v = 4'(i);
                e = 1'b0;
            end
        end
    endfunction

    function automatic int active_digit(input logic [3:0] an);
        int d = 0;
        for (int i = 0; i < NDIG; i++) if (!an[i]) d = i;
        return d;
    endfunction

    // From idle, a qualified pattern held at least SC cycles yields exactly one commit.
    task automatic step(input string tag, input logic [6:0] seg, input logic [3:0] an,
                        input int len);
        int p0 = pulses;
        logic q;
        logic [3:0] v;
        logic e;
        drive(seg, an);
        run(len);
        drive(7'h7F, 4'hF);
        run(3);
        q = ($countones(~an) == 1) && (seg != 7'h7F);
        if (q && len >= int'(SC)) begin
            model_decode(seg, v, e);
            chk({tag, " pulses"}, 32'(pulses - p0), 32'd1);
            chk({tag, " idx"}, 32'(cap_idx), 32'(active_digit(an)));
            chk({tag, " val"}, 32'(cap_val), 32'(v));
            chk({tag, " err"}, 32'(cap_err), 32'(e));
            if (e) exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
            else   exp_dig[active_digit(an)] = v;
        end else begin
            chk({tag, " no pulse"}, 32'(pulses - p0), 32'd0);
        end
        chk({tag, " digits"}, 32'(bus.digits_o), 32'(exp_vec()));
        chk({tag, " err_cnt"}, 32'(bus.err_cnt), 32'(exp_err_cnt));
    endtask

    initial begin
        int lat;
        int p0;
        logic [6:0] seg;
        logic [3:0] an;
        int d, len, k;

        for (int i = 0; i < NDIG; i++) exp_dig[i] = 4'd0;
        exp_err_cnt = 0;
        rst = 1'b1;
        drive(7'h7F, 4'hF);
        run(3);
        chk("reset valid", 32'(bus.valid_o), 32'd0);
        chk("reset idx/val/err", {27'd0, bus.idx_o, bus.val_o, bus.err_o}, 32'd0);
        chk("reset digits", 32'(bus.digits_o), 32'd0);
        chk("reset err_cnt", 32'(bus.err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(2);

        // Single digit latency.
        p0  = pulses;
        lat = 0;
        drive(7'b0100100, 4'b1101);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.valid_o === 1'b1 && lat == 0) begin
                lat = i;
                pulses++;
                cap_idx = bus.idx_o;
                cap_val = bus.val_o;
                cap_err = bus.err_o;
            end
            if (i == 10) drive(7'h7F, 4'hF);
        end
        chk("latency", 32'(lat), 32'(SC + 1));
        chk("single pulses", 32'(pulses - p0), 32'd1);
        chk("single idx", 32'(cap_idx), 32'd1);
        chk("single val", 32'(cap_val), 32'd2);
        chk("single slot", 32'(bus.digits_o[7:4]), 32'd2);
        exp_dig[1] = 4'd2;

        // Back-to-back scan of all four digits.
        p0 = pulses;
        drive(7'b1111001, 4'b1110); run(6);
        drive(7'b0110000, 4'b1101); run(6);
        drive(7'b0010010, 4'b1011); run(6);
        drive(7'b0000010, 4'b0111); run(6);
        drive(7'h7F, 4'hF); run(3);
        chk("scan pulses", 32'(pulses - p0), 32'd4);
        chk("scan digits", 32'(bus.digits_o), 32'h6531);
        exp_dig[0] = 4'd1; exp_dig[1] = 4'd3; exp_dig[2] = 4'd5; exp_dig[3] = 4'd6;

        // Unstable, blank and ambiguous-anode patterns.
        p0 = pulses;
        drive(7'b0011001, 4'b1110); run(SC - 1);
        drive(7'b0010010, 4'b1110); run(SC - 1);
        drive(7'b0011001, 4'b1110); run(SC - 1);
        drive(7'h7F, 4'hF); run(3);
        chk("toggle no pulse", 32'(pulses - p0), 32'd0);
        step("blank", 7'h7F, 4'b1110, 20);
        step("two anodes", 7'b0100100, 4'b1001, 20);
        step("no anode", 7'b0100100, 4'b1111, 20);

        // All-segments-lit pattern: error unless hex decode is enabled.
        step("eight", 7'b0000000, 4'b1011, 8);

        for (int n = 0; n < 40; n++) begin
            d = $urandom_range(0, NDIG - 1);
            k = $urandom_range(0, 9);
            if (k < 8)       an = ~(4'b0001 << d);
            else if (k == 8) an = 4'hF;
            else             an = ~((4'b0001 << d) | (4'b0001 << ((d + 1) % NDIG)));
            k = $urandom_range(0, 9);
            if (k < 4)       seg = TBL[$urandom_range(0, 15)];
            else if (k == 4) seg = 7'h7F;
            else             seg = 7'($urandom);
            len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, SC - 1)
                                              : $urandom_range(SC, SC + 5);
            step("random", seg, an, len);
        end

        // Reset asserted mid-track.
        p0 = pulses;
        drive(7'b0110000, 4'b1011);
        run(2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst valid", 32'(bus.valid_o), 32'd0);
        chk("async rst digits", 32'(bus.digits_o), 32'd0);
        chk("async rst err_cnt", 32'(bus.err_cnt), 32'd0);
        drive(7'h7F, 4'hF);
        run(2);
        @(negedge clk);
        rst = 1'b0;
        run(10);
        chk("rst no pulse", 32'(pulses - p0), 32'd0);
        for (int i = 0; i < NDIG; i++) exp_dig[i] = 4'd0;
        exp_err_cnt = 0;

        // Error counter saturation.
        p0 = pulses;
        for (int n = 0; n < 300; n++) begin
            drive(7'b0101010, (n % 2 == 0) ? 4'b1110 : 4'b1101);
            run(SC + 2);
            exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
        end
        drive(7'h7F, 4'hF);
        run(3);
        chk("sat pulses", 32'(pulses - p0), 32'd300);
        chk("sat err_cnt", 32'(bus.err_cnt), 32'(exp_err_cnt));
        chk("sat err_o", 32'(bus.err_o), 32'd1);
        chk("sat digits", 32'(bus.digits_o), 32'(exp_vec()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
